// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, flush, freeze and halt/drain sequencing for the five-stage pipeline
module pipeline_ctrl #(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_r1_pos,
   input  logic [4:0]  id_r2_pos,
   input  logic        id_uses_r1,
   input  logic        id_uses_r2,
   input  logic [4:0]  ex_dst,
   input  logic        ex_is_load,
   input  logic        branch_taken,
   input  logic        halt_req,
   input  logic        mem_busy,
   input  logic        go,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_clr,
   output logic        idex_en,
   output logic        idex_clr,
   output logic        exmem_en,
   output logic        exmem_clr,
   output logic        memwb_en,
   output logic        memwb_clr,
   output logic        halted,
   output logic [31:0] cycle_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_drain_cnt;
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   logic        w_hazard;
   logic        w_draining;

   // Register 0 is hard-wired zero, so a load targeting it never forwards a hazard.
   assign w_hazard = ex_is_load && (ex_dst != 5'd0) &&
                     ((id_uses_r1 && (id_r1_pos == ex_dst)) ||
                      (id_uses_r2 && (id_r2_pos == ex_dst)));

   assign w_draining = (r_state == S_DRAIN) || halt_req;

   always_comb begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      ifid_clr  = 1'b0;
      idex_en   = 1'b1;
      idex_clr  = 1'b0;
      exmem_en  = 1'b1;
      exmem_clr = 1'b0;
      memwb_en  = 1'b1;
      memwb_clr = 1'b0;
      if (!rst_n) begin
         pc_en     = 1'b0;
         ifid_clr  = 1'b1;
         idex_clr  = 1'b1;
         exmem_clr = 1'b1;
         memwb_clr = 1'b1;
      end else if (r_state == S_HALTED || mem_busy) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (w_draining) begin
         pc_en    = 1'b0;
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (branch_taken) begin
         ifid_clr = 1'b1;
         idex_clr = 1'b1;
      end else if (w_hazard) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_clr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_drain_cnt <= 4'd0;
         r_cycle_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else if (r_state == S_HALTED) begin
         if (go) begin
            r_state <= S_RUN;
         end
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (!mem_busy) begin
            if (r_state == S_DRAIN) begin
               if (r_drain_cnt == 4'd0) begin
                  r_state <= S_HALTED;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 4'd1;
               end
            end else if (halt_req) begin
               r_state     <= S_DRAIN;
               r_drain_cnt <= DRAIN_INIT;
            end else if (branch_taken) begin
               r_flush_cnt <= r_flush_cnt + 32'd1;
            end else if (w_hazard) begin
               r_stall_cnt <= r_stall_cnt + 32'd1;
            end
         end
      end
   end

   assign halted    = (r_state == S_HALTED);
   assign cycle_cnt = r_cycle_cnt;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the `en`/`clr` pair of each of the four inter-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves load-use stalls, taken-branch flushes, data-memory wait freezes and the syscall-exit halt/drain sequence. It also keeps cycle, stall and flush counters for the debug display.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles spent draining EX/MEM/WB after a halt request before the pipeline freezes (1..15).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- id_r1_pos  in  5  source register 1 index of the instruction in ID.
- id_r2_pos  in  5  source register 2 index of the instruction in ID.
- id_uses_r1  in  1  the ID instruction reads r1.
- id_uses_r2  in  1  the ID instruction reads r2.
- ex_dst  in  5  destination register of the instruction in EX.
- ex_is_load  in  1  the EX instruction is a load (lw/lb/lh…).
- branch_taken  in  1  the EX instruction is a taken branch or jump; the PC loads its target this cycle.
- halt_req  in  1  the EX instruction is a syscall exit (v0 == 10).
- mem_busy  in  1  data memory has not completed this cycle.
- go  in  1  resume request; honoured only in HALTED.
- pc_en  out  1  PC write enable.
- ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr  out  1 each  buffer controls. A buffer captures when en=1. With en=1 and clr=1 it captures a bubble (IR=0, signal=0).
- halted  out  1  high while in HALTED.
- cycle_cnt  out  32  cycles spent in RUN or DRAIN.
- stall_cnt  out  32  load-use bubbles inserted.
- flush_cnt  out  32  taken-branch flushes.

## Operation
States: RUN, DRAIN, HALTED. drain_cnt is a 4-bit down-counter.

Per-cycle action, highest priority first:
1. rst_n=0
   - Outputs: pc_en=0; all four buffers en=1 clr=1, so the pipeline fills with bubbles.
   - Next state: RUN. drain_cnt=0. All counters 0. halted=0.
2. HALTED
   - Outputs: all en=0, clr=0, pc_en=0, halted=1.
   - go=1 → RUN next cycle.
3. mem_busy=1 (in RUN or DRAIN)
   - Outputs: all en=0, pc_en=0 (freeze).
   - State, drain_cnt, stall_cnt and flush_cnt unchanged. cycle_cnt increments.
4. DRAIN
   - Outputs: pc_en=0; ifid en=1 clr=1; idex en=1 clr=1; exmem and memwb en=1 clr=0.
   - If drain_cnt==0 → HALTED; else drain_cnt−1.
5. RUN with halt_req=1
   - Outputs: same as DRAIN.
   - Next state: DRAIN with drain_cnt=DRAIN_CYCLES−1.
   - halt_req wins over a simultaneous branch_taken. flush_cnt is not incremented.
6. RUN with branch_taken=1
   - Outputs: pc_en=1; ifid en=1 clr=1; idex en=1 clr=1; exmem and memwb normal.
   - flush_cnt+1. Overrides any concurrent load-use condition; stall_cnt is not incremented.
7. RUN with load-use hazard
   - Hazard condition: ex_is_load && ex_dst!=0 && ((id_uses_r1 && id_r1_pos==ex_dst) || (id_uses_r2 && id_r2_pos==ex_dst)).
   - Outputs: pc_en=0; ifid_en=0; idex en=1 clr=1; exmem and memwb normal.
   - stall_cnt+1.
8. RUN otherwise
   - Outputs: all en=1, all clr=0, pc_en=1.

Register 0 never creates a hazard. go outside HALTED is ignored. Counters wrap modulo 2^32. cycle_cnt increments in RUN and DRAIN and is held in HALTED and reset.

## Timing
- Outputs are combinational from the registered state and the current-cycle inputs. Zero latency: the buffers and PC act on them at the next rising edge.
- A load-use stall lasts exactly one cycle. The next cycle sees the bubble in EX, so the hazard clears by itself.
- halted rises in the cycle after the last DRAIN cycle. Total halt_req→halted latency is DRAIN_CYCLES+1 edges, plus any mem_busy cycles.
- Reset asserted mid-DRAIN or in HALTED returns the block to RUN with counters cleared on that edge.
- go in HALTED: RUN takes effect at the next edge, with normal enables from that cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → pc_en=0, all en=1/clr=1, counters 0. Release → all en=1, clr=0, pc_en=1, cycle_cnt counting 1,2,3…
- Load-use: ex_is_load=1, ex_dst=8, id_uses_r2=1, id_r2_pos=8 for one cycle → pc_en=0, ifid_en=0, idex_clr=1, stall_cnt=1. Repeat with ex_dst=0 → no stall.
- Branch plus hazard in the same cycle: branch_taken=1 together with a load-use match → pc_en=1, ifid_clr=1, idex_clr=1, flush_cnt=1, stall_cnt unchanged.
- Halt with DRAIN_CYCLES=2: halt_req pulse → 2 cycles of ifid/idex bubbles with exmem/memwb enabled, then halted=1 and all en=0. cycle_cnt freezes. go=1 → RUN next edge.
- mem_busy asserted for 3 cycles during DRAIN → all en=0 and drain_cnt held. halted is delayed by exactly 3 cycles.
- Reset asserted in HALTED → next edge state is RUN, halted=0, counters 0. go=1 while in RUN → no effect.
